accum_norm: RTL

ACCUM_NORM -- requirements
Module: accum_norm

---
 rtl/accum_norm.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/accum_norm.sv
// accum_norm: turns a free-running 48-bit upstream accumulator into one
// normalised, saturated 8-bit pixel per window of TAPS taps. The window sum
// is the difference of the accumulator across the window, which makes it
// immune to upstream wrap-around. Results go through a 2-entry output FIFO;
// when the consumer stalls long enough to fill it, new pixels are dropped and
// a sticky overflow flag is raised.
module accum_norm #(
    parameter int TAPS  = 9,
    parameter int SHIFT = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        tap_valid,
    input  logic [47:0] accum_in,
    output logic [7:0]  pix_out,
    output logic        pix_valid,
    input  logic        pix_ready,
    output logic        sat_flag,
    output logic        overflow
);

    localparam int CNT_W = (TAPS > 1) ? $clog2(TAPS) : 1;
    localparam logic [CNT_W-1:0] LAST_TAP = CNT_W'(TAPS - 1);
    // Half an output LSB; the shift-then-halve form yields 0 when SHIFT is 0.
    localparam logic signed [48:0] RND = (49'sd1 <<< SHIFT) >>> 1;

    // Round-half-up and arithmetic shift; one guard bit keeps the rounding
    // addition from overflowing near the top of the 48-bit range.
    function automatic logic signed [48:0] round_shift(input logic signed [47:0] s);
        logic signed [48:0] ext;
        ext = {s[47], s};
        return (ext + RND) >>> SHIFT;
    endfunction

    // Clip to the unsigned 8-bit pixel range; bit 8 flags that clipping happened.
    function automatic logic [8:0] saturate(input logic signed [48:0] r);
        logic [8:0] res;
        if (r < 0)
            res = {1'b1, 8'h00};
        else if (r > 49'sd255)
            res = {1'b1, 8'hFF};
        else
            res = {1'b0, r[7:0]};
        return res;
    endfunction

    logic [CNT_W-1:0]    tap_cnt;
    logic                win_end;
    logic [47:0]         base;
    logic signed [47:0]  s1_p0;
    logic                vld_p0;
    logic [8:0]          res_p1;
    logic [8:0]          tail_data;
    logic                tail_vld;
    logic                push;
    logic                pop;
    logic                head_load_tail;
    logic                head_load_new;
    logic                tail_load;
    logic                drop;

    assign win_end = tap_valid && (tap_cnt == LAST_TAP);

    // Tap position inside the current window; wraps on the last tap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            tap_cnt <= '0;
        else if (win_end)
            tap_cnt <= '0;
        else if (tap_valid)
            tap_cnt <= tap_cnt + 1'b1;
    end

    // ---- stage 1: window sum as modulo difference against the previous window end
    // Window-end base and stage-1 valid; base advances even if the pixel is later dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            base   <= '0;
            vld_p0 <= 1'b0;
        end else begin
            vld_p0 <= win_end;
            if (win_end)
                base <= accum_in;
        end
    end

    // Stage-1 sum data register; only qualified by vld_p0, so it needs no reset.
    always_ff @(posedge clk) begin
        if (win_end)
            s1_p0 <= accum_in - base;
    end

    // ---- stage 2: normalise and saturate, written straight into the output FIFO
    assign res_p1 = saturate(round_shift(s1_p0));

    // FIFO steering: head register drives the outputs, tail is the second entry.
    always_comb begin
        push           = vld_p0;
        pop            = pix_valid && pix_ready;
        head_load_tail = 1'b0;
        head_load_new  = 1'b0;
        tail_load      = 1'b0;
        drop           = 1'b0;
        if (pop && tail_vld) begin
            head_load_tail = 1'b1;
            tail_load      = push;
        end else if (pop || !pix_valid) begin
            head_load_new  = push;
        end else if (!tail_vld) begin
            tail_load      = push;
        end else begin
            drop           = push;
        end
    end

    // Head entry, occupancy flags and sticky overflow; head holds after the last pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pix_out   <= 8'h00;
            sat_flag  <= 1'b0;
            pix_valid <= 1'b0;
            tail_vld  <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            if (head_load_tail) begin
                pix_out   <= tail_data[7:0];
                sat_flag  <= tail_data[8];
                pix_valid <= 1'b1;
            end else if (head_load_new) begin
                pix_out   <= res_p1[7:0];
                sat_flag  <= res_p1[8];
                pix_valid <= 1'b1;
            end else if (pop) begin
                pix_valid <= 1'b0;
            end
            if (tail_load)
                tail_vld <= 1'b1;
            else if (head_load_tail)
                tail_vld <= 1'b0;
            if (drop)
                overflow <= 1'b1;
        end
    end

    // Second FIFO entry data; meaningful only while tail_vld is set.
    always_ff @(posedge clk) begin
        if (tail_load)
            tail_data <= res_p1;
    end

endmodule
